mem_stage_access: RTL and testbench

- Consumer end of the execute-stage output bundle: the EXE/MEM pipeline register, the data-memory access controller and the MEM/WB pipeline register in one block.
- Latches WB/MEM enables, ALU result, Rm value and destination from the execute stage.
- Runs a variable-latency req/ready access to data memory for loads and stores, freezing upstream stages until the access completes.
- Presents registered results to the write-back stage.

---
 rtl/mem_stage_access_pkg.sv | 15 +
 rtl/mem_stage_access_fsm.sv | 94 +++++++++
 rtl/mem_stage_access.sv | 119 +++++++++++
 tb/tb_mem_stage_access.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_access_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, default data-memory base address,
// and the data value substituted when an access is aborted.
// No ports; imported by mem_access_fsm and mem_stage_access.
package mem_stage_access_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam int unsigned DEF_BASE_ADDR = 1024;
   localparam logic [31:0] ABORT_DATA    = 32'hDEADBEEF;

endpackage

// File: rtl/mem_stage_access_fsm.sv
// Data-memory access controller: state register, optional timeout counter, captured read data.
// Latency: IDLE -> ACCESS (waits for mem_ready_i) -> DONE; minimum three cycles per memory op.
// Backpressure: freeze_o holds upstream while a memory op is pending; derived from registers only.
// Ports: clk_i/rst_ni clock and async active-low reset; mem_r_i/mem_w_i registered op flags;
//        mem_ready_i/mem_rdata_i memory response; freeze_o stall; rd_en_o/wr_en_o requests;
//        rdata_o captured data; err_o sticky abort flag.
// Optional: MEM_TIMEOUT_EN enables the ACCESS timeout and err_o; otherwise err_o is tied low.
module mem_access_fsm
   import mem_stage_access_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        mem_r_i,
   input  logic        mem_w_i,
   input  logic        mem_ready_i,
   input  logic [31:0] mem_rdata_i,
   output logic        freeze_o,
   output logic        rd_en_o,
   output logic        wr_en_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   if (TIMEOUT < 1) begin : g_timeout_chk
      $error("mem_access_fsm: TIMEOUT must be at least 1");
   end

   state_e      state_q;
   logic [31:0] rdata_q;
   logic        memop;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;
`endif

   assign memop = mem_r_i | mem_w_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (memop) state_q <= ACCESS;
`ifdef MEM_TIMEOUT_EN
               // Held at zero while idle, so every ACCESS starts from a clean count.
               cnt_q <= '0;
`endif
            end
            ACCESS: begin
               // A response on the final allowed cycle still wins over the abort.
               if (mem_ready_i) begin
                  rdata_q <= mem_rdata_i;
                  state_q <= DONE;
               end
`ifdef MEM_TIMEOUT_EN
               else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  rdata_q <= ABORT_DATA;
                  err_q   <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Stall everything until the DONE cycle, when the stage register may reload.
   assign freeze_o = memop & (state_q != DONE);
   // A store takes priority when both flags are set.
   assign wr_en_o  = (state_q == ACCESS) & mem_w_i;
   assign rd_en_o  = (state_q == ACCESS) & mem_r_i & ~mem_w_i;
   assign rdata_o  = rdata_q;

`ifdef MEM_TIMEOUT_EN
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: rtl/mem_stage_access.sv
// Memory stage: EXE/MEM register, data-memory access controller and MEM/WB register.
// Latency: non-memory op one cycle R->WB; memory op valid two edges after memReady.
// Backpressure: freeze stalls IF/ID/EXE while a load/store is outstanding; WB sees bubbles.
// Ports: clk/rst (async active-low); *In execute-stage bundle; freeze stall out;
//        memAddr/memWData/memRdEn/memWrEn/memReady/memRData data-memory handshake;
//        *Out, memDataOut registered write-back bundle; memErr sticky abort flag.
// Optional: MEM_TIMEOUT_EN enables the ACCESS timeout (TIMEOUT cycles) and memErr.
module mem_stage_access
   import mem_stage_access_pkg::*;
#(
   parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              WB_ENIn,
   input  logic              MEM_R_ENIn,
   input  logic              MEM_W_ENIn,
   input  logic [31:0]       ALU_ResIn,
   input  logic [31:0]       Val_RmIn,
   input  logic [3:0]        DestIn,
   output logic              freeze,
   output logic [ADDR_W-1:0] memAddr,
   output logic [31:0]       memWData,
   output logic              memRdEn,
   output logic              memWrEn,
   input  logic              memReady,
   input  logic [31:0]       memRData,
   output logic              WB_ENOut,
   output logic              MEM_R_ENOut,
   output logic [31:0]       ALU_ResOut,
   output logic [31:0]       memDataOut,
   output logic [3:0]        DestOut,
   output logic              memErr
);

   // EXE/MEM stage register
   logic        wb_q;
   logic        mem_r_q;
   logic        mem_w_q;
   logic [31:0] alu_res_q;
   logic [31:0] val_rm_q;
   logic [3:0]  dest_q;

   // MEM/WB register
   logic        wb_out_q;
   logic        mem_r_out_q;
   logic [31:0] alu_out_q;
   logic [31:0] data_out_q;
   logic [3:0]  dest_out_q;

   logic [31:0] cap_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_q      <= 1'b0;
         mem_r_q   <= 1'b0;
         mem_w_q   <= 1'b0;
         alu_res_q <= '0;
         val_rm_q  <= '0;
         dest_q    <= '0;
      end else if (!freeze) begin
         wb_q      <= WB_ENIn;
         mem_r_q   <= MEM_R_ENIn;
         mem_w_q   <= MEM_W_ENIn;
         alu_res_q <= ALU_ResIn;
         val_rm_q  <= Val_RmIn;
         dest_q    <= DestIn;
      end
   end

   mem_access_fsm #(
      .TIMEOUT (TIMEOUT)
   ) u_fsm (
      .clk_i       (clk),
      .rst_ni      (rst),
      .mem_r_i     (mem_r_q),
      .mem_w_i     (mem_w_q),
      .mem_ready_i (memReady),
      .mem_rdata_i (memRData),
      .freeze_o    (freeze),
      .rd_en_o     (memRdEn),
      .wr_en_o     (memWrEn),
      .rdata_o     (cap_data),
      .err_o       (memErr)
   );

   // Byte address relative to the memory base, as a word index; wraps below the base.
   assign memAddr  = ADDR_W'((alu_res_q - 32'(BASE_ADDR)) >> 2);
   assign memWData = val_rm_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_out_q    <= 1'b0;
         mem_r_out_q <= 1'b0;
         alu_out_q   <= '0;
         data_out_q  <= '0;
         dest_out_q  <= '0;
      end else if (!freeze) begin
         wb_out_q    <= wb_q;
         mem_r_out_q <= mem_r_q;
         alu_out_q   <= alu_res_q;
         data_out_q  <= cap_data;
         dest_out_q  <= dest_q;
      end else begin
         // Stalled: feed a bubble to write-back, keep the data fields.
         wb_out_q    <= 1'b0;
         mem_r_out_q <= 1'b0;
      end
   end

   assign WB_ENOut    = wb_out_q;
   assign MEM_R_ENOut = mem_r_out_q;
   assign ALU_ResOut  = alu_out_q;
   assign memDataOut  = data_out_q;
   assign DestOut     = dest_out_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access: table of ops with expected WB results and stall lengths,
// a behavioural data memory with per-op response delay, and hand-written reset sequences.
// Build with MEM_TIMEOUT_EN defined to include the timeout case.
module tb_mem_stage_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        WB_ENIn, MEM_R_ENIn, MEM_W_ENIn;
   logic [31:0] ALU_ResIn, Val_RmIn;
   logic [3:0]  DestIn;
   logic        freeze;
   logic [5:0]  memAddr;
   logic [31:0] memWData;
   logic        memRdEn, memWrEn;
   logic        memReady = 1'b0;
   logic [31:0] memRData = '0;
   logic        WB_ENOut, MEM_R_ENOut;
   logic [31:0] ALU_ResOut, memDataOut;
   logic [3:0]  DestOut;
   logic        memErr;

   always #5 clk = ~clk;

   mem_stage_access #(
      .BASE_ADDR (1024),
      .ADDR_W    (6),
      .TIMEOUT   (15)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .WB_ENIn     (WB_ENIn),
      .MEM_R_ENIn  (MEM_R_ENIn),
      .MEM_W_ENIn  (MEM_W_ENIn),
      .ALU_ResIn   (ALU_ResIn),
      .Val_RmIn    (Val_RmIn),
      .DestIn      (DestIn),
      .freeze      (freeze),
      .memAddr     (memAddr),
      .memWData    (memWData),
      .memRdEn     (memRdEn),
      .memWrEn     (memWrEn),
      .memReady    (memReady),
      .memRData    (memRData),
      .WB_ENOut    (WB_ENOut),
      .MEM_R_ENOut (MEM_R_ENOut),
      .ALU_ResOut  (ALU_ResOut),
      .memDataOut  (memDataOut),
      .DestOut     (DestOut),
      .memErr      (memErr)
   );

   typedef struct {
      logic        wb, rd, wr;
      logic [31:0] alu, rm;
      logic [3:0]  dest;
      int          dly;       // ACCESS cycle in which memory answers; 0 = never
      logic [31:0] rdata;
      logic [5:0]  addr;      // expected word address
      int          frz;       // expected stall cycles while the op sits in R
      logic [31:0] exp_data;  // expected memDataOut for loads
   } vec_t;

   typedef struct {
      logic        wb, mr;
      logic [31:0] alu;
      logic [3:0]  dest;
      logic        chk_data;
      logic [31:0] data;
      int          frz;
   } out_t;

   typedef struct {
      logic [5:0]  addr;
      logic        rd, wr;
      logic [31:0] wdata;
      int          dly;
      logic [31:0] rdata;
   } req_t;

   vec_t vt[$];
   out_t sb_q[$];
   req_t rq_q[$];

   int n_chk = 0;
   int n_pass = 0;
   logic drv_vld = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic vec_t mk(input logic wb, input logic rd, input logic wr,
                               input logic [31:0] alu, input logic [31:0] rm,
                               input logic [3:0] dest, input int dly,
                               input logic [31:0] rdata, input logic [5:0] addr,
                               input int frz, input logic [31:0] exp_data);
      vec_t v;
      v.wb = wb; v.rd = rd; v.wr = wr; v.alu = alu; v.rm = rm; v.dest = dest;
      v.dly = dly; v.rdata = rdata; v.addr = addr; v.frz = frz; v.exp_data = exp_data;
      return v;
   endfunction

   // Present an op, queue its expectations, return on the negedge after it is accepted.
   task automatic send(input vec_t v);
      out_t o;
      req_t r;
      int   budget;
      WB_ENIn = v.wb; MEM_R_ENIn = v.rd; MEM_W_ENIn = v.wr;
      ALU_ResIn = v.alu; Val_RmIn = v.rm; DestIn = v.dest;
      drv_vld = 1'b1;
      o.wb = v.wb; o.mr = v.rd; o.alu = v.alu; o.dest = v.dest;
      o.chk_data = v.rd; o.data = v.exp_data; o.frz = v.frz;
      sb_q.push_back(o);
      if (v.rd || v.wr) begin
         r.addr = v.addr; r.rd = v.rd & ~v.wr; r.wr = v.wr;
         r.wdata = v.rm; r.dly = v.dly; r.rdata = v.rdata;
         rq_q.push_back(r);
      end
      budget = 0;
      while (freeze !== 1'b0 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 200) begin
         n_chk++;
         $display("FAIL accept: freeze=%b after %0d cycles, required 0", freeze, budget);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      WB_ENIn = 0; MEM_R_ENIn = 0; MEM_W_ENIn = 0;
      ALU_ResIn = '0; Val_RmIn = '0; DestIn = '0;
      drv_vld = 1'b0;
   endtask

   task automatic drain();
      int b = 0;
      while (sb_q.size() != 0 && b < 100) begin
         @(negedge clk);
         b++;
      end
      if (sb_q.size() != 0) begin
         n_chk++;
         $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
      end
   endtask

   // Behavioural data memory: checks each request on its first cycle, answers after dly cycles.
   req_t cur;
   bit   acc_on = 0;
   int   acc_cyc = 0;
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         acc_on = 0; memReady = 1'b0; memRData = '0;
      end else if (memRdEn || memWrEn) begin
         if (!acc_on) begin
            acc_on = 1; acc_cyc = 0;
            if (rq_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_request: rd=%b wr=%b addr=%h, required none", memRdEn, memWrEn, memAddr);
               cur = '{default: 0};
            end else begin
               cur = rq_q.pop_front();
               chk("mem_addr", 32'(memAddr), 32'(cur.addr));
               chk("mem_rd_en", 32'(memRdEn), 32'(cur.rd));
               chk("mem_wr_en", 32'(memWrEn), 32'(cur.wr));
               if (cur.wr) chk("mem_wdata", memWData, cur.wdata);
            end
         end
         acc_cyc++;
         if (cur.dly != 0 && acc_cyc == cur.dly) begin
            memReady = 1'b1; memRData = cur.rdata;
         end else begin
            memReady = 1'b0; memRData = '0;
         end
      end else begin
         acc_on = 0; memReady = 1'b0; memRData = '0;
      end
   end

   // Output monitor: decides at each negedge what the next clock edge will do, then
   // checks the result at the following negedge.
   bit   mon_en = 0, r_vld = 0, out_due = 0, bub_due = 0;
   int   frz_run = 0, frz_snap = 0;
   out_t mo;
   always @(negedge clk) begin
      #2;
      if (!mon_en) begin
         r_vld = 0; out_due = 0; bub_due = 0; frz_run = 0;
      end else begin
         if (out_due) begin
            if (sb_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_output: WB_ENOut=%b DestOut=%h, required none", WB_ENOut, DestOut);
            end else begin
               mo = sb_q.pop_front();
               chk("wb_en_out", 32'(WB_ENOut), 32'(mo.wb));
               chk("mem_r_en_out", 32'(MEM_R_ENOut), 32'(mo.mr));
               chk("alu_res_out", ALU_ResOut, mo.alu);
               chk("dest_out", 32'(DestOut), 32'(mo.dest));
               if (mo.chk_data) chk("mem_data_out", memDataOut, mo.data);
               chk("freeze_cycles", frz_snap, mo.frz);
            end
         end
         if (bub_due) begin
            chk("bubble_wb_en", 32'(WB_ENOut), 32'd0);
            chk("bubble_mem_r_en", 32'(MEM_R_ENOut), 32'd0);
         end
         out_due = 0; bub_due = 0;
         if (freeze) begin
            frz_run++;
            bub_due = 1;
         end else begin
            if (r_vld) begin
               out_due = 1;
               frz_snap = frz_run;
            end
            frz_run = 0;
            r_vld = drv_vld;
         end
      end
   end

   initial begin
      rst = 1'b0;
      idle();

      //         wb rd wr alu            rm            dest dly rdata         addr   frz exp_data
      vt.push_back(mk(1, 0, 0, 32'd5,         32'h0,        4'd3,  0, 32'h0,        6'h00, 0, 32'h0));
      vt.push_back(mk(1, 1, 0, 32'd1032,      32'h0,        4'd4,  2, 32'h0000A5A5, 6'h02, 3, 32'h0000A5A5));
      vt.push_back(mk(0, 0, 1, 32'd1040,      32'h77,       4'd0,  1, 32'h0,        6'h04, 2, 32'h0));
      vt.push_back(mk(1, 1, 0, 32'd1044,      32'h0,        4'd5,  1, 32'h12345678, 6'h05, 2, 32'h12345678));
      vt.push_back(mk(1, 1, 0, 32'd1020,      32'h0,        4'd6,  3, 32'hCAFEF00D, 6'h3F, 4, 32'hCAFEF00D));
      vt.push_back(mk(1, 0, 0, 32'hFFFFFFFF,  32'h0,        4'd15, 0, 32'h0,        6'h00, 0, 32'h0));
      vt.push_back(mk(0, 1, 1, 32'd1028,      32'h5555AAAA, 4'd2,  2, 32'h600DCAFE, 6'h01, 3, 32'h600DCAFE));
      vt.push_back(mk(0, 0, 0, 32'h100,       32'h0,        4'd7,  0, 32'h0,        6'h00, 0, 32'h0));
      vt.push_back(mk(1, 1, 0, 32'd1280,      32'h0,        4'd8,  1, 32'h89ABCDEF, 6'h00, 2, 32'h89ABCDEF));
`ifdef MEM_TIMEOUT_EN
      vt.push_back(mk(1, 1, 0, 32'd1048,      32'h0,        4'd10, 0, 32'h0,        6'h06, 16, 32'hDEADBEEF));
`endif

      // Reset state
      #1;
      chk("rst_freeze", 32'(freeze), 32'd0);
      chk("rst_rd_en", 32'(memRdEn), 32'd0);
      chk("rst_wr_en", 32'(memWrEn), 32'd0);
      chk("rst_wb_en_out", 32'(WB_ENOut), 32'd0);
      chk("rst_mem_data_out", memDataOut, 32'd0);
      chk("rst_mem_err", 32'(memErr), 32'd0);

      repeat (2) @(negedge clk);
      rst = 1'b1;
      mon_en = 1;

      foreach (vt[i]) send(vt[i]);
      idle();
      drain();
`ifdef MEM_TIMEOUT_EN
      chk("mem_err_set", 32'(memErr), 32'd1);
`else
      chk("mem_err_tied", 32'(memErr), 32'd0);
`endif

      // ALU op immediately followed by a load that never gets an answer; reset mid-access.
      @(negedge clk);
      send(mk(1, 0, 0, 32'h0BEEF000, 32'h0, 4'd12, 0, 32'h0, 6'h00, 0, 32'h0));
      send(mk(1, 1, 0, 32'd1036, 32'h0, 4'd9, 0, 32'h0, 6'h03, 0, 32'h0));
      idle();
      repeat (2) @(negedge clk);
      #1;
      chk("access_rd_en", 32'(memRdEn), 32'd1);
      chk("access_freeze", 32'(freeze), 32'd1);
`ifdef MEM_TIMEOUT_EN
      chk("mem_err_sticky", 32'(memErr), 32'd1);
`endif
      mon_en = 0;
      rst = 1'b0;
      #1;
      chk("arst_rd_en", 32'(memRdEn), 32'd0);
      chk("arst_wr_en", 32'(memWrEn), 32'd0);
      chk("arst_freeze", 32'(freeze), 32'd0);
      chk("arst_wb_en_out", 32'(WB_ENOut), 32'd0);
      chk("arst_mem_r_en_out", 32'(MEM_R_ENOut), 32'd0);
      chk("arst_alu_res_out", ALU_ResOut, 32'd0);
      chk("arst_dest_out", 32'(DestOut), 32'd0);
      chk("arst_mem_data_out", memDataOut, 32'd0);
      chk("arst_mem_err", 32'(memErr), 32'd0);
      chk("arst_mem_addr", 32'(memAddr), 32'd0);
      sb_q.delete();
      rq_q.delete();

      @(negedge clk);
      rst = 1'b1;
      mon_en = 1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle_freeze", 32'(freeze), 32'd0);
      chk("post_rst_idle_rd_en", 32'(memRdEn), 32'd0);

      // Recovery: a normal load after reset starts from IDLE.
      send(mk(1, 1, 0, 32'd1052, 32'h0, 4'd11, 1, 32'h0BADF00D, 6'h07, 2, 32'h0BADF00D));
      idle();
      drain();
      chk("req_queue_empty", 32'(rq_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
